// File: rtl/bcd_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_tx
//  Description : Accepts a binary value (0..99) on a start/ready handshake,
//                converts it to two BCD digits by repeated subtraction of 10
//                and shifts the packed byte {tens, units} out MSB first, one
//                bit per clock, with an optional idle gap after each byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_tx #(
    parameter int GAP_BITS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] value,
    output logic       ready,
    output logic       s_out,
    output logic       s_valid,
    output logic       err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [6:0] c_TEN      = 7'd10;
    localparam logic [6:0] c_MAX_VAL  = 7'd99;
    localparam logic [2:0] c_LAST_BIT = 3'd7;
    localparam logic       c_HAS_GAP  = (GAP_BITS > 0);
    // Last gap-counter value before returning to IDLE; unused when no gap.
    localparam logic [3:0] c_GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    logic [1:0] r_state;
    logic [6:0] r_rem;
    logic [3:0] r_tens;
    logic [7:0] r_shreg;
    logic [2:0] r_cnt;
    logic [3:0] r_gcnt;

    logic [1:0] w_state_nxt;
    logic [6:0] w_rem_nxt;
    logic [3:0] w_tens_nxt;
    logic [7:0] w_shreg_nxt;
    logic [2:0] w_cnt_nxt;
    logic [3:0] w_gcnt_nxt;
    logic       w_ready_nxt;
    logic       w_s_out_nxt;
    logic       w_s_valid_nxt;
    logic       w_err_nxt;

    // State, datapath and registered outputs; reset abandons any byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= 7'd0;
            r_tens  <= 4'd0;
            r_shreg <= 8'd0;
            r_cnt   <= 3'd0;
            r_gcnt  <= 4'd0;
            ready   <= 1'b1;
            s_out   <= 1'b0;
            s_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_tens  <= w_tens_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gcnt  <= w_gcnt_nxt;
            ready   <= w_ready_nxt;
            s_out   <= w_s_out_nxt;
            s_valid <= w_s_valid_nxt;
            err     <= w_err_nxt;
        end
    end

    // Next-state logic; output values are computed one cycle ahead so the
    // serial bit appears registered in the cycle that follows each edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_rem_nxt     = r_rem;
        w_tens_nxt    = r_tens;
        w_shreg_nxt   = r_shreg;
        w_cnt_nxt     = r_cnt;
        w_gcnt_nxt    = r_gcnt;
        w_s_out_nxt   = 1'b0;
        w_s_valid_nxt = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && ready) begin
                    if (value > c_MAX_VAL) begin
                        // Out-of-range request: flag it and stay available.
                        w_err_nxt = 1'b1;
                    end else begin
                        w_rem_nxt   = value;
                        w_tens_nxt  = 4'd0;
                        w_state_nxt = S_CONV;
                    end
                end
            end

            S_CONV: begin
                if (r_rem >= c_TEN) begin
                    w_rem_nxt  = r_rem - c_TEN;
                    w_tens_nxt = r_tens + 4'd1;
                end else begin
                    // Conversion done: load the byte and present its MSB now.
                    w_shreg_nxt   = {r_tens, r_rem[3:0]};
                    w_cnt_nxt     = 3'd0;
                    w_s_out_nxt   = r_tens[3];
                    w_s_valid_nxt = 1'b1;
                    w_state_nxt   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                w_shreg_nxt = {r_shreg[6:0], 1'b0};
                w_cnt_nxt   = r_cnt + 3'd1;
                if (r_cnt == c_LAST_BIT) begin
                    w_gcnt_nxt  = 4'd0;
                    w_state_nxt = c_HAS_GAP ? S_GAP : S_IDLE;
                end else begin
                    // Bit 6 of the pre-shift register becomes the next MSB.
                    w_s_out_nxt   = r_shreg[6];
                    w_s_valid_nxt = 1'b1;
                end
            end

            S_GAP: begin
                w_gcnt_nxt = r_gcnt + 4'd1;
                if (r_gcnt == c_GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_ready_nxt = (w_state_nxt == S_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_serial_tx
//  Description : Scoreboard bench for bcd_serial_tx. Stimulus pushes the
//                expected byte (or -1 for an err pulse) per instance; monitors
//                rebuild bytes from s_out/s_valid and compare in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start3;
    logic [6:0] value0, value3;
    logic       ready0, so0, sv0, err0;
    logic       ready3, so3, sv3, err3;

    int n_checks = 0;
    int n_fail   = 0;
    int q0[$];
    int q3[$];

    always #5 clk = ~clk;

    bcd_serial_tx #(.GAP_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .value(value0),
        .ready(ready0), .s_out(so0), .s_valid(sv0), .err(err0)
    );

    bcd_serial_tx #(.GAP_BITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .value(value3),
        .ready(ready3), .s_out(so3), .s_valid(sv3), .err(err3)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the no-gap instance.
    logic [7:0] by0;
    int         bc0 = 0;
    always @(negedge clk) begin
        if (rst) begin
            bc0 = 0;
        end else begin
            if (err0) begin
                if (q0.size() == 0) chk("dut0 unexpected err", 1, 0);
                else chk("dut0 err order", q0.pop_front(), -1);
            end
            if (sv0) begin
                by0 = {by0[6:0], so0};
                bc0++;
                if (bc0 == 8) begin
                    bc0 = 0;
                    if (q0.size() == 0) chk("dut0 unexpected byte", int'(by0), -99);
                    else chk("dut0 byte", int'(by0), q0.pop_front());
                end
            end
        end
    end

    // Monitor for the gap instance.
    logic [7:0] by3;
    int         bc3 = 0;
    always @(negedge clk) begin
        if (rst) begin
            bc3 = 0;
        end else begin
            if (err3) begin
                if (q3.size() == 0) chk("dut3 unexpected err", 1, 0);
                else chk("dut3 err order", q3.pop_front(), -1);
            end
            if (sv3) begin
                by3 = {by3[6:0], so3};
                bc3++;
                if (bc3 == 8) begin
                    bc3 = 0;
                    if (q3.size() == 0) chk("dut3 unexpected byte", int'(by3), -99);
                    else chk("dut3 byte", int'(by3), q3.pop_front());
                end
            end
        end
    end

    task automatic wait_idle0();
        for (int i = 0; i < 100; i++) begin
            if (ready0 && q0.size() == 0) return;
            tick();
        end
        chk("dut0 idle timeout", 0, 1);
    endtask

    initial begin
        int first_sv;
        int first_rdy;
        int err_seen;
        int sv_cnt;
        int gap_idle;
        int rdy_b;
        int vals[2];

        rst = 1'b1; start0 = 1'b0; value0 = 7'd0; start3 = 1'b0; value3 = 7'd0;
        repeat (2) tick();
        chk("reset ready", ready0, 1);
        chk("reset s_out", so0, 0);
        chk("reset s_valid", sv0, 0);
        chk("reset err", err0, 0);
        chk("reset ready gap", ready3, 1);
        rst = 1'b0;
        tick();

        // value=60, no gap: bits after E7..E14, ready after E15.
        q0.push_back(8'h60);
        start0 = 1'b1; value0 = 7'd60;
        tick();
        start0 = 1'b0;
        chk("60 ready drop", ready0, 0);
        first_sv = -1; first_rdy = -1; err_seen = err0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            err_seen |= err0;
            if (first_sv < 0 && sv0) first_sv = i;
            if (ready0) begin first_rdy = i; break; end
        end
        chk("60 first bit edge", first_sv, 7);
        chk("60 ready edge", first_rdy, 15);
        chk("60 no err", err_seen, 0);
        wait_idle0();

        // value=0 then 99 with start held high.
        q0.push_back(8'h00);
        q0.push_back(8'h99);
        start0 = 1'b1; value0 = 7'd0;
        tick();
        value0 = 7'd99;
        first_sv = -1; first_rdy = -1;
        for (int i = 1; i <= 80; i++) begin
            rdy_b = ready0;
            tick();
            if (first_sv < 0 && sv0) first_sv = i;
            if (first_rdy < 0 && ready0) first_rdy = i;
            if (rdy_b) begin start0 = 1'b0; break; end
        end
        chk("0 first bit edge", first_sv, 1);
        chk("0 ready edge", first_rdy, 9);
        chk("held start released", start0, 0);
        wait_idle0();

        // Out-of-range values: one-cycle err, ready stays high, no data.
        vals[0] = 100; vals[1] = 127;
        for (int k = 0; k < 2; k++) begin
            q0.push_back(-1);
            start0 = 1'b1; value0 = 7'(vals[k]);
            tick();
            start0 = 1'b0;
            chk("err pulse", err0, 1);
            chk("err ready", ready0, 1);
            chk("err s_valid", sv0, 0);
            tick();
            chk("err clear", err0, 0);
            chk("err ready after", ready0, 1);
        end
        tick();

        // Reset during bit 3 of 47; the byte is abandoned (nothing queued).
        start0 = 1'b1; value0 = 7'd47;
        tick();
        start0 = 1'b0;
        repeat (8) tick();
        chk("47 in shift", sv0, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst s_valid", sv0, 0);
        chk("rst s_out", so0, 0);
        chk("rst ready", ready0, 1);
        tick();
        rst = 1'b0;
        sv_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            sv_cnt += int'(sv0);
        end
        chk("no bits after rst", sv_cnt, 0);
        q0.push_back(8'h12);
        start0 = 1'b1; value0 = 7'd12;
        tick();
        start0 = 1'b0;
        wait_idle0();

        // start mid-SHIFT with another value must be ignored.
        q0.push_back(8'h25);
        start0 = 1'b1; value0 = 7'd25;
        tick();
        start0 = 1'b0;
        repeat (5) tick();
        chk("mid shift busy", ready0, 0);
        start0 = 1'b1; value0 = 7'd81;
        tick();
        start0 = 1'b0; value0 = 7'd0;
        wait_idle0();
        repeat (30) tick();

        // GAP_BITS=3, value=5: bits after E1..E8, idle E9..E11, ready after E12.
        q3.push_back(8'h05);
        start3 = 1'b1; value3 = 7'd5;
        tick();
        start3 = 1'b0;
        first_sv = -1; first_rdy = -1; sv_cnt = 0; gap_idle = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (first_sv < 0 && sv3) first_sv = i;
            sv_cnt += int'(sv3);
            if (i >= 9 && i <= 11 && !sv3 && !ready3 && !so3) gap_idle++;
            if (ready3) begin first_rdy = i; break; end
        end
        chk("gap first bit edge", first_sv, 1);
        chk("gap bit count", sv_cnt, 8);
        chk("gap idle cycles", gap_idle, 3);
        chk("gap ready edge", first_rdy, 12);

        repeat (5) tick();
        chk("dut0 queue drained", q0.size(), 0);
        chk("dut3 queue drained", q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
